// File: rtl/sipo_pkg.sv
// rtl/sipo_pkg.sv - shared states and line levels for the serial deframer
package sipo_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } state_e;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/sipo_shift.sv
// rtl/sipo_shift.sv - WIDTH-bit serial-in shift register, direction set by MSB_FIRST
module sipo_shift #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift_en_i,
  input  logic             sin_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // Shifting toward the MSB leaves the first bit received in q[WIDTH-1].
  always_comb begin
    if (MSB_FIRST) begin
      q_d = {q_q[WIDTH-2:0], sin_i};
    end else begin
      q_d = {sin_i, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else if (shift_en_i) begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/sipo_deframer.sv
// rtl/sipo_deframer.sv - start/data/stop frame receiver with a valid/ready word output
module sipo_deframer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             po_valid_q, po_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             shift_en;
  logic             commit;
  logic [WIDTH-1:0] word;

  sipo_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_shift (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en),
    .sin_i      (sin),
    .q_o        (word)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_en    = 1'b0;
    commit      = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    po_d        = po_q;
    po_valid_d  = po_valid_q;

    unique case (state_q)
      IDLE: begin
        if (sin == START_BIT) begin
          state_d = DATA;
          cnt_d   = '0;
        end
      end
      DATA: begin
        shift_en = 1'b1;
        // Clear on the last bit so the counter never wraps inside a frame.
        if (cnt_q == LAST_BIT) begin
          state_d = STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        state_d = IDLE;
        if (sin == STOP_BIT) begin
          commit = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An accept on the commit edge frees the slot for the new word.
    if (commit) begin
      if (!po_valid_q || po_ready) begin
        po_d       = word;
        po_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (po_valid_q && po_ready) begin
      po_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      po_q        <= '0;
      po_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      po_q        <= po_d;
      po_valid_q  <= po_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign po        = po_q;
  assign po_valid  = po_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/sipo_deframer.md
Name: sipo_deframer

Overview:
Serial-to-parallel receiver that consumes the single-bit stream produced by the team's PISO shift stage.
- Detects a framed word: one start bit, WIDTH data bits MSB first, one stop bit, at one bit per clock.
- Checks the stop bit and presents the word on a parallel valid/ready output interface.
- Sits directly downstream of piso_shift; a unit under test ties its `sin` to the PISO `sout`.

Parameters:
- WIDTH, 4: number of data bits per frame (≥2).
- MSB_FIRST, 1: 1 = the first data bit received lands in `po[WIDTH-1]`; 0 = it lands in `po[0]`.

Ports:
- clk  in  1  rising-edge clock; one serial bit sampled per edge.
- rst  in  1  asynchronous, active-high reset.
- sin  in  1  serial input; idles at 1.
- po  out  WIDTH  received word, stable while `po_valid`=1.
- po_valid  out  1  word available; held until accepted.
- po_ready  in  1  consumer accepts the word when `po_valid` and `po_ready` are both 1 on a rising edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled as 0.
- overrun  out  1  one-cycle pulse: a new word completed while the old word was still unaccepted.
- busy  out  1  1 whenever the state is not IDLE.

Behaviour:
- Reset (async assert, any state): state=IDLE, bit counter=0, shift register=0, `po`=0, `po_valid`=0, `frame_err`=0, `overrun`=0, `busy`=0.
- Release of reset takes effect on the next rising edge.
- FSM states:
  - IDLE: `sin`=0 sampled → DATA, counter←0. Otherwise stay in IDLE.
  - DATA: shift in `sin` per MSB_FIRST; counter++. On the edge where counter==WIDTH-1, shift in the last bit → STOP.
  - STOP: sample `sin`, then → IDLE unconditionally.
    - `sin`=1 → commit the shift register to the output.
    - `sin`=0 → `frame_err` pulses 1 cycle; word discarded; output register untouched.
- Frame length is WIDTH+2 clocks.
- Back-to-back frames are supported with one idle bit (the stop bit) between them. A start bit may arrive on the edge immediately after STOP→IDLE.
- Commit and handshake:
  - Commit with `po_valid`=0, or with `po_valid`=1 and `po_ready`=1 on the same edge: `po`←new word, `po_valid`←1. No overrun.
  - Commit with `po_valid`=1 and `po_ready`=0: new word dropped; `po` and `po_valid` unchanged; `overrun` pulses 1 cycle.
  - No commit, `po_valid` and `po_ready` both 1: `po_valid`←0; `po` retains its value.
- Latency: `po_valid` rises on the edge that samples the stop bit, i.e. visible the cycle after the stop bit is presented.
- `po_ready` is ignored while `po_valid`=0.
- A 0 on `sin` in IDLE always starts a frame; there is no glitch filtering.
- Errors are pulses only; there is no sticky status.
- Counter width is $clog2(WIDTH) and never wraps inside a frame.
- Reset mid-frame: the partial word is lost and no `frame_err` is raised. After reset, the next 0 on `sin` is treated as a start bit.

Decomposition:
- Shared package `sipo_pkg`:
  - state enum {IDLE, DATA, STOP};
  - constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1.
- One natural sub-module, `sipo_shift`: a WIDTH-bit shift register with shift-enable and direction parameter, async reset to 0.
- The FSM, counter and output handshake stay in the top.

Test Plan (WIDTH=4, MSB_FIRST=1, `po_ready`=1 unless noted):
1. `sin` stream 1,1,0,1,0,1,0,1 → `po`=4'b1010, `po_valid`=1 for one cycle after the stop edge; `frame_err`=0, `overrun`=0.
2. Two frames back-to-back: 0,1,0,1,0,1 then 0,1,1,0,1,1 → `po`=1010, then `po`=1101 exactly 6 clocks later; `busy` low for only 1 cycle between frames.
3. Bad stop bit: 0,1,1,1,1,0 → `frame_err` pulses 1 cycle; `po_valid` stays 0; `po` keeps its previous value; FSM back in IDLE and the next frame 0,0,0,1,1,1 gives `po`=0011.
4. `po_ready`=0, send 1010 then 0110 → `po`=1010 held with `po_valid`=1; `overrun` pulses on the second stop edge. Then raise `po_ready` → `po_valid` drops the next cycle.
5. Commit with simultaneous accept: `po_valid`=1 holding 1010, `po_ready`=1 on the stop edge of frame 0110 → `po`=0110, `po_valid` stays 1, `overrun`=0.
6. Assert `rst` asynchronously mid-frame after 2 data bits → all outputs 0 immediately (before the next edge). After release, frame 0,1,1,1,1,1 → `po`=4'b1111 with no `frame_err`.
